// File: rtl/fpnew_pkg.sv
// FPU shared types: rounding modes, operations, formats and status flags.
// Latency: none, type definitions only.
// Backpressure: not applicable.
// Ports: none.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    E5M2    = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8  = 2'd0,
    INT16 = 2'd1,
    INT32 = 2'd2,
    INT64 = 2'd3
  } int_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

endpackage

// File: rtl/fpnew_issue_rob_if.sv
// Bundle of core request, FPU issue/return and in-order response signals.
// Latency: none, wiring only.
// Backpressure: valid/ready on request, FPU input, FPU output and response.
// Modports: slave = issue ROB side, master = surrounding core/FPU side.
interface fpnew_issue_rob_if #(
  parameter int unsigned Width   = 64,
  parameter int unsigned NumTags = 4
);
  import fpnew_pkg::*;

  localparam int unsigned TagW = $clog2(NumTags);

  // core request
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [2:0][Width-1:0] req_operands_i;
  roundmode_e            req_rnd_mode_i;
  operation_e            req_op_i;
  logic                  req_op_mod_i;
  fp_format_e            req_src_fmt_i;
  fp_format_e            req_dst_fmt_i;
  int_format_e           req_int_fmt_i;
  logic                  req_vectorial_op_i;

  // FPU input side
  logic [2:0][Width-1:0] fpu_operands_o;
  roundmode_e            fpu_rnd_mode_o;
  operation_e            fpu_op_o;
  logic                  fpu_op_mod_o;
  fp_format_e            fpu_src_fmt_o;
  fp_format_e            fpu_dst_fmt_o;
  int_format_e           fpu_int_fmt_o;
  logic                  fpu_vectorial_op_o;
  logic [TagW-1:0]       fpu_tag_o;
  logic                  fpu_valid_o;
  logic                  fpu_in_ready_i;
  logic                  fpu_flush_o;

  // FPU output side
  logic [Width-1:0]      fpu_result_i;
  status_t               fpu_status_i;
  logic [TagW-1:0]       fpu_tag_i;
  logic                  fpu_out_valid_i;
  logic                  fpu_out_ready_o;
  logic                  fpu_busy_i;

  // control and in-order response
  logic                  flush_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [Width-1:0]      rsp_result_o;
  status_t               rsp_status_o;
  logic                  spurious_o;
  logic                  busy_o;

  modport slave (
    input  req_valid_i, req_operands_i, req_rnd_mode_i, req_op_i, req_op_mod_i,
           req_src_fmt_i, req_dst_fmt_i, req_int_fmt_i, req_vectorial_op_i,
           fpu_in_ready_i, fpu_result_i, fpu_status_i, fpu_tag_i,
           fpu_out_valid_i, fpu_busy_i, flush_i, rsp_ready_i,
    output req_ready_o, fpu_operands_o, fpu_rnd_mode_o, fpu_op_o, fpu_op_mod_o,
           fpu_src_fmt_o, fpu_dst_fmt_o, fpu_int_fmt_o, fpu_vectorial_op_o,
           fpu_tag_o, fpu_valid_o, fpu_flush_o, fpu_out_ready_o,
           rsp_valid_o, rsp_result_o, rsp_status_o, spurious_o, busy_o
  );

  modport master (
    output req_valid_i, req_operands_i, req_rnd_mode_i, req_op_i, req_op_mod_i,
           req_src_fmt_i, req_dst_fmt_i, req_int_fmt_i, req_vectorial_op_i,
           fpu_in_ready_i, fpu_result_i, fpu_status_i, fpu_tag_i,
           fpu_out_valid_i, fpu_busy_i, flush_i, rsp_ready_i,
    input  req_ready_o, fpu_operands_o, fpu_rnd_mode_o, fpu_op_o, fpu_op_mod_o,
           fpu_src_fmt_o, fpu_dst_fmt_o, fpu_int_fmt_o, fpu_vectorial_op_o,
           fpu_tag_o, fpu_valid_o, fpu_flush_o, fpu_out_ready_o,
           rsp_valid_o, rsp_result_o, rsp_status_o, spurious_o, busy_o
  );

endinterface

// File: rtl/fpnew_rob_mem.sv
// Reorder buffer payload storage: one entry per tag.
// Latency: write lands at the clock edge, read is combinational.
// Backpressure: none, write enable is owned by the caller.
// Ports: clk_i, we/waddr/wdata (tag-indexed write), raddr/rdata (retire read).
module fpnew_rob_mem #(
  parameter int unsigned NumTags = 4,
  parameter type         entry_t = logic,
  localparam int unsigned TagW   = $clog2(NumTags)
) (
  input  logic            clk_i,
  input  logic            we,
  input  logic [TagW-1:0] waddr,
  input  entry_t          wdata,
  input  logic [TagW-1:0] raddr,
  output entry_t          rdata
);

  // payload only; validity lives in the alloc/done flags of the owner
  entry_t mem [NumTags];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fpnew_issue_rob.sv
// Tags FP ops toward the FPU and returns their results to the core in issue order.
// Latency: issue is combinational; a returned result is visible at rsp the next cycle.
// Backpressure: issue stalls when NumTags ops are in flight; rsp holds until rsp_ready_i.
// Ports: clk_i, rst_i (sync, active-high), bus (fpnew_issue_rob_if.slave).
module fpnew_issue_rob
  import fpnew_pkg::*;
#(
  parameter int unsigned Width   = 64,
  parameter int unsigned NumTags = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fpnew_issue_rob_if.slave   bus
);

  localparam int unsigned   TagW    = $clog2(NumTags);
  localparam logic [TagW:0] CntFull = NumTags[TagW:0];
  localparam logic [TagW:0] CntOne  = 1;
  localparam logic [TagW-1:0] PtrOne = 1;

  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
  } rob_entry_t;

  logic [TagW-1:0]    wr_ptr, rd_ptr;
  logic [TagW:0]      count, count_nxt;
  logic [NumTags-1:0] alloc, done;

  logic       full, fpu_valid, rsp_valid;
  logic       issue, retire, res_hit, res_take;
  rob_entry_t wr_entry, rd_entry;

  // full comes from the registered count only, so a retire in this cycle
  // never frees a slot for an issue in the same cycle
  assign full = (count == CntFull);

  // valid must not look at fpu_in_ready_i: the FPU derives ready from valid
  assign fpu_valid = bus.req_valid_i & ~full & ~bus.flush_i & ~rst_i;
  assign issue     = fpu_valid & bus.fpu_in_ready_i;

  assign bus.fpu_valid_o = fpu_valid;
  assign bus.req_ready_o = bus.fpu_in_ready_i & ~full & ~bus.flush_i & ~rst_i;
  assign bus.fpu_tag_o   = wr_ptr;
  assign bus.fpu_flush_o = bus.flush_i;

  assign bus.fpu_operands_o     = bus.req_operands_i;
  assign bus.fpu_rnd_mode_o     = bus.req_rnd_mode_i;
  assign bus.fpu_op_o           = bus.req_op_i;
  assign bus.fpu_op_mod_o       = bus.req_op_mod_i;
  assign bus.fpu_src_fmt_o      = bus.req_src_fmt_i;
  assign bus.fpu_dst_fmt_o      = bus.req_dst_fmt_i;
  assign bus.fpu_int_fmt_o      = bus.req_int_fmt_i;
  assign bus.fpu_vectorial_op_o = bus.req_vectorial_op_i;

  // slots are reserved at issue, so the return path never needs to stall
  assign bus.fpu_out_ready_o = ~rst_i;

  // only an allocated, not-yet-completed tag may accept a result;
  // anything else (stale after flush, duplicate) is dropped and flagged
  assign res_hit        = alloc[bus.fpu_tag_i] & ~done[bus.fpu_tag_i];
  assign res_take       = bus.fpu_out_valid_i & res_hit & ~bus.flush_i & ~rst_i;
  assign bus.spurious_o = bus.fpu_out_valid_i & ~res_hit & ~rst_i;

  assign rsp_valid        = done[rd_ptr] & ~rst_i;
  assign retire           = rsp_valid & bus.rsp_ready_i & ~bus.flush_i;
  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.rsp_result_o = rd_entry.result;
  assign bus.rsp_status_o = rd_entry.status;

  // count may hold stale contents during the first reset cycle, hence the gate
  assign bus.busy_o = (~rst_i & (count != '0)) | bus.fpu_busy_i;

  assign wr_entry.result = bus.fpu_result_i;
  assign wr_entry.status = bus.fpu_status_i;

  always_comb begin
    count_nxt = count;
    case ({issue, retire})
      2'b10:   count_nxt = count + CntOne;
      2'b01:   count_nxt = count - CntOne;
      default: count_nxt = count;
    endcase
  end

  // issue targets wr_ptr and retire targets rd_ptr; these coincide only when
  // the ROB is empty (no retire) or full (no issue), so the updates never collide
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      alloc  <= '0;
      done   <= '0;
    end else begin
      if (issue) begin
        alloc[wr_ptr] <= 1'b1;
        done[wr_ptr]  <= 1'b0;
        wr_ptr        <= wr_ptr + PtrOne;
      end
      if (res_take) begin
        done[bus.fpu_tag_i] <= 1'b1;
      end
      if (retire) begin
        alloc[rd_ptr] <= 1'b0;
        done[rd_ptr]  <= 1'b0;
        rd_ptr        <= rd_ptr + PtrOne;
      end
      count <= count_nxt;
    end
  end

  fpnew_rob_mem #(
    .NumTags (NumTags),
    .entry_t (rob_entry_t)
  ) u_mem (
    .clk_i (clk_i),
    .we    (res_take),
    .waddr (bus.fpu_tag_i),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

endmodule
